// File: rtl/encrypt_sequencer.sv
// Control FSM for the Program 1 encryption datapath: loads pre/taps/seed, then emits 64 LFSR-keyed bytes.
// Optional feature macro: ENCRYPT_PARITY_EN (even parity of the 7-bit ciphertext in bit 7).
module encrypt_sequencer #(
    parameter int unsigned N_CHARS  = 64,
    parameter int unsigned MSG_MAX  = 54,
    parameter int unsigned CFG_BASE = 61,
    parameter int unsigned OUT_BASE = 64
) (
    input  logic       clk,
    input  logic       init,
    input  logic       req,
    output logic       ack,
    output logic       busy,
    output logic [7:0] mem_addr,
    output logic       mem_wr_en,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE, LD_PRE, LD_TAP, LD_SEED, RD, WR, DONE
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] idx_q, idx_d;
    logic [6:0] lfsr_q, lfsr_d;
    logic [6:0] taps_q, taps_d;
    logic [7:0] pre_q, pre_d;
    logic [6:0] pt_q, pt_d;
    logic       ack_q, ack_d;

    logic [7:0] msg_off;
    logic       pt_zero;
    logic [6:0] ct;
    logic       bit7;
    logic       wr_req;

    // Negative offsets are caught by the idx<pre test, so the 8-bit difference never wraps into range.
    assign msg_off = {1'b0, idx_q} - pre_q;
    assign pt_zero = ({1'b0, idx_q} < pre_q) || (msg_off >= 8'(MSG_MAX));
    assign ct      = pt_q ^ lfsr_q;

`ifdef ENCRYPT_PARITY_EN
    assign bit7 = ^ct;
`else
    assign bit7 = 1'b0;
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
        state_d   = state_q;
        idx_d     = idx_q;
        lfsr_d    = lfsr_q;
        taps_d    = taps_q;
        pre_d     = pre_q;
        pt_d      = pt_q;
        ack_d     = ack_q || (state_q == DONE);
        busy      = 1'b0;
        wr_req    = 1'b0;
        mem_addr  = 8'd0;
        mem_wdata = 8'd0;

        unique case (state_q)
            IDLE: begin
                if (!req) state_d = LD_PRE;
            end
            LD_PRE: begin
                busy     = 1'b1;
                mem_addr = 8'(CFG_BASE);
                pre_d    = mem_rdata;
                state_d  = LD_TAP;
            end
            LD_TAP: begin
                busy     = 1'b1;
                mem_addr = 8'(CFG_BASE + 1);
                taps_d   = mem_rdata[6:0];
                state_d  = LD_SEED;
            end
            LD_SEED: begin
                busy     = 1'b1;
                mem_addr = 8'(CFG_BASE + 2);
                lfsr_d   = mem_rdata[6:0];
                idx_d    = 7'd0;
                state_d  = RD;
            end
            RD: begin
                busy     = 1'b1;
                mem_addr = msg_off;
                pt_d     = pt_zero ? 7'd0 : mem_rdata[6:0];
                state_d  = WR;
            end
            WR: begin
                busy      = 1'b1;
                wr_req    = 1'b1;
                mem_addr  = 8'(OUT_BASE) + {1'b0, idx_q};
                mem_wdata = {bit7, ct};
                lfsr_d    = {lfsr_q[5:0], ^(lfsr_q & taps_q)};
                idx_d     = idx_q + 7'd1;
                state_d   = (idx_q == 7'(N_CHARS - 1)) ? DONE : RD;
            end
            DONE: begin
                // Sticky until init; req is ignored here.
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the strobe is gated combinationally so a reset cycle can never commit a write.
    assign mem_wr_en = wr_req && !init;
    assign ack       = ack_q;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (init) begin
            state_q <= IDLE;
            idx_q   <= 7'd0;
            lfsr_q  <= 7'd0;
            taps_q  <= 7'd0;
            pre_q   <= 8'd0;
            pt_q    <= 7'd0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lfsr_q  <= lfsr_d;
            taps_q  <= taps_d;
            pre_q   <= pre_d;
            pt_q    <= pt_d;
            ack_q   <= ack_d;
        end
    end

endmodule

// File: tb/tb_encrypt_sequencer.sv
// Directed self-checking bench for encrypt_sequencer with a behavioural data memory.
// Build with +define+ENCRYPT_PARITY_EN to check the parity variant.
module tb_encrypt_sequencer;

    logic       clk;
    logic       init;
    logic       req;
    logic       ack;
    logic       busy;
    logic [7:0] mem_addr;
    logic       mem_wr_en;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    logic [7:0] in_mem [0:255];
    logic [7:0] out_mem [0:63];
    logic [7:0] exp_out [0:63];
    int         wr_count;
    int         bad_wr;
    int         busy_cycles;
    int         n_checks;
    int         n_fail;

    encrypt_sequencer dut (
        .clk       (clk),
        .init      (init),
        .req       (req),
        .ack       (ack),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = in_mem[mem_addr];

    initial begin
        wr_count    = 0;
        bad_wr      = 0;
        busy_cycles = 0;
    end

    always @(posedge clk) begin
        if (busy) busy_cycles <= busy_cycles + 1;
        if (mem_wr_en) begin
            wr_count <= wr_count + 1;
            if (mem_addr < 8'd64 || mem_addr > 8'd127) bad_wr <= bad_wr + 1;
            else out_mem[mem_addr[5:0]] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] enc(input logic [6:0] c);
`ifdef ENCRYPT_PARITY_EN
        return {^c, c};
`else
        return {1'b0, c};
`endif
    endfunction

    task automatic load_cfg(input logic [7:0] pre, input logic [7:0] taps, input logic [7:0] seed);
        in_mem[61] = pre;
        in_mem[62] = taps;
        in_mem[63] = seed;
    endtask

    task automatic clear_msg();
        for (int i = 0; i < 61; i++) in_mem[i] = 8'h00;
    endtask

    // Reference keystream/ciphertext model built from the bench's own memory image.
    task automatic build_expected();
        logic [6:0] lfsr;
        logic [6:0] taps;
        logic [6:0] pt;
        int         pre;
        int         d;
        lfsr = in_mem[63][6:0];
        taps = in_mem[62][6:0];
        pre  = int'(in_mem[61]);
        for (int i = 0; i < 64; i++) begin
            d  = i - pre;
            pt = (d >= 0 && d < 54) ? in_mem[d][6:0] : 7'd0;
            exp_out[i] = enc(pt ^ lfsr);
            lfsr = {lfsr[5:0], ^(lfsr & taps)};
        end
    endtask

    task automatic do_reset();
        @(negedge clk) init = 1'b1;
        @(posedge clk);
        @(negedge clk) init = 1'b0;
    endtask

    // Launch with req low for one edge, then count edges until ack (bounded).
    task automatic launch_and_wait(input bit toggle, output int edges);
        @(negedge clk) req = 1'b0;
        @(posedge clk);
        @(negedge clk) req = 1'b1;
        edges = 0;
        while (edges < 300) begin
            @(posedge clk);
            #1;
            edges++;
            if (toggle && edges >= 10 && edges < 18) req = edges[0];
            if (ack) break;
        end
    endtask

    task automatic run_and_check(input string tag, input bit toggle);
        int edges;
        int wr0;
        int b0;
        build_expected();
        wr0 = wr_count;
        b0  = busy_cycles;
        launch_and_wait(toggle, edges);
        check({tag, "_ack_edge"}, edges, 132);
        check({tag, "_ack"}, ack, 1);
        check({tag, "_busy_done"}, busy, 0);
        check({tag, "_writes"}, wr_count - wr0, 64);
        check({tag, "_busy_cycles"}, busy_cycles - b0, 131);
        check({tag, "_bad_wr"}, bad_wr, 0);
        for (int i = 0; i < 64; i++)
            check($sformatf("%s_byte%0d", tag, i), out_mem[i], exp_out[i]);
    endtask

    initial begin
        int wr0;
        int b_snap;
        n_checks = 0;
        n_fail   = 0;
        init     = 1'b1;
        req      = 1'b1;
        for (int i = 0; i < 256; i++) in_mem[i] = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        @(negedge clk) init = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("hold_busy", busy, 0);
        check("hold_writes", wr_count, 0);

        // Zero message: pure keystream from byte 10 onwards, keystream everywhere
        clear_msg();
        load_cfg(8'd10, 8'h60, 8'h01);
        run_and_check("zero", 1'b0);
        check("zero_hand0", out_mem[0], enc(7'h01));
        check("zero_hand1", out_mem[1], enc(7'h02));
        check("zero_hand2", out_mem[2], enc(7'h04));
        check("zero_hand3", out_mem[3], enc(7'h08));
        check("zero_hand4", out_mem[4], enc(7'h10));
        check("zero_hand5", out_mem[5], enc(7'h20));
        check("zero_hand6", out_mem[6], enc(7'h41));
        do_reset();
        #1 check("zero_rst_ack", ack, 0);

        // "Mr." biased, keystream at idx 10..12 = 18,30,61
        clear_msg();
        in_mem[0] = 8'h2D;
        in_mem[1] = 8'h52;
        in_mem[2] = 8'h0E;
        load_cfg(8'd10, 8'h60, 8'h01);
        run_and_check("mr", 1'b0);
        check("mr_hand10", out_mem[10], enc(7'h35));
        check("mr_hand11", out_mem[11], enc(7'h62));
        check("mr_hand12", out_mem[12], enc(7'h6F));
        do_reset();

        // Seed with only bit 7 set -> zero keystream, output is shifted plaintext
        for (int i = 0; i < 54; i++) in_mem[i] = 8'(i + 'h21);
        for (int i = 54; i < 61; i++) in_mem[i] = 8'h7F;
        load_cfg(8'd26, 8'h7B, 8'h80);
        run_and_check("zks", 1'b0);
        for (int i = 0; i < 64; i++)
            check($sformatf("zks_direct%0d", i), out_mem[i],
                  (i < 26) ? 8'h00 : enc(7'(i - 26 + 'h21)));
        do_reset();

        // pre=0: bytes past MSG_MAX must not read 54..60
        load_cfg(8'd0, 8'h7B, 8'h80);
        run_and_check("pre0", 1'b0);
        for (int i = 50; i < 64; i++)
            check($sformatf("pre0_direct%0d", i), out_mem[i],
                  (i < 54) ? enc(7'(i + 'h21)) : 8'h00);
        do_reset();

        // pre>=64: whole output is keystream
        load_cfg(8'd200, 8'h60, 8'h05);
        run_and_check("pre200", 1'b0);
        do_reset();

        // Reset in the middle of a run, during a write cycle
        clear_msg();
        in_mem[0] = 8'h11;
        load_cfg(8'd5, 8'h60, 8'h01);
        wr0 = wr_count;
        @(negedge clk) req = 1'b0;
        @(posedge clk);
        @(negedge clk) req = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check("mid_in_wr", mem_wr_en, 1);
        check("mid_writes_before", wr_count - wr0, 23);
        init = 1'b1;
        #1;
        check("mid_wr_gated", mem_wr_en, 0);
        @(posedge clk);
        #1;
        check("mid_ack", ack, 0);
        check("mid_busy", busy, 0);
        check("mid_writes_at_rst", wr_count - wr0, 23);
        @(negedge clk) init = 1'b0;
        b_snap = busy_cycles;
        repeat (20) @(posedge clk);
        #1;
        check("mid_idle_writes", wr_count - wr0, 23);
        check("mid_idle_busy", busy_cycles - b_snap, 0);
        check("mid_idle_addr", mem_addr, 0);
        load_cfg(8'd3, 8'h41, 8'h2A);
        run_and_check("restart", 1'b0);
        do_reset();

        // req toggling during the run and after ack
        clear_msg();
        in_mem[0] = 8'h2D;
        in_mem[1] = 8'h52;
        in_mem[2] = 8'h0E;
        load_cfg(8'd10, 8'h60, 8'h01);
        run_and_check("tog", 1'b1);
        wr0    = wr_count;
        b_snap = busy_cycles;
        for (int k = 0; k < 8; k++) @(negedge clk) req = k[0];
        repeat (10) @(posedge clk);
        #1;
        check("tog_ack_held", ack, 1);
        check("tog_no_busy", busy_cycles - b_snap, 0);
        check("tog_no_writes", wr_count - wr0, 0);
        do_reset();
        #1 check("tog_rst_ack", ack, 0);

        // Parity-oriented run: seed 0x03 gives 03, 06 (both even parity)
        clear_msg();
        load_cfg(8'd0, 8'h60, 8'h03);
        run_and_check("par", 1'b0);
        check("par_byte0", out_mem[0], 8'h03);
        check("par_byte1", out_mem[1], 8'h06);
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
